// File: rtl/rename_dual.sv
// Two-wide register rename stage: architectural RAT with value/ready per entry,
// circular free list of physical tags, multi-port wakeup and a stall handshake.
module rename_dual #(
  parameter int  NUM_PHYS   = 64,
  parameter int  DATA_W     = 32,
  parameter int  NUM_WAKEUP = 2,
  parameter int  NUM_FREE   = 2,
  localparam int TAG_W      = $clog2(NUM_PHYS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   ard0,
  input  logic [4:0]                   ars1_0,
  input  logic [4:0]                   ars2_0,
  input  logic [4:0]                   ard1,
  input  logic [4:0]                   ars1_1,
  input  logic [4:0]                   ars2_1,
  output logic [TAG_W-1:0]             prd0,
  output logic [TAG_W-1:0]             prd1,
  output logic [TAG_W-1:0]             prs1_0,
  output logic [TAG_W-1:0]             prs2_0,
  output logic [TAG_W-1:0]             prs1_1,
  output logic [TAG_W-1:0]             prs2_1,
  output logic                         rs1_ready_0,
  output logic                         rs2_ready_0,
  output logic                         rs1_ready_1,
  output logic                         rs2_ready_1,
  output logic [DATA_W-1:0]            rs1_value_0,
  output logic [DATA_W-1:0]            rs2_value_0,
  output logic [DATA_W-1:0]            rs1_value_1,
  output logic [DATA_W-1:0]            rs2_value_1,
  input  logic [NUM_WAKEUP-1:0]        wakeup_active,
  input  logic [NUM_WAKEUP*TAG_W-1:0]  wakeup_tag,
  input  logic [NUM_WAKEUP*DATA_W-1:0] wakeup_value,
  input  logic [NUM_FREE*TAG_W-1:0]    freed_tag,
  output logic [TAG_W:0]               free_count,
  output logic                         error
);

  localparam int NUM_ARCH = 32;
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  rat_tag     [NUM_ARCH];
  logic [TAG_W-1:0]  rat_tag_n   [NUM_ARCH];
  logic [DATA_W-1:0] rat_value   [NUM_ARCH];
  logic [DATA_W-1:0] rat_value_n [NUM_ARCH];
  logic              rat_ready   [NUM_ARCH];
  logic              rat_ready_n [NUM_ARCH];

  logic [TAG_W-1:0]  fl   [DEPTH];
  logic [TAG_W-1:0]  fl_n [DEPTH];
  logic [PTR_W-1:0]  head, head_n, head_p1;
  logic [PTR_W-1:0]  tail, tail_n;
  logic [TAG_W:0]    count_n;
  logic              error_n;

  logic [1:0]        need;
  logic [TAG_W:0]    need_cnt;
  logic              accept;

  logic [TAG_W-1:0]  wk_tag   [NUM_WAKEUP];
  logic [DATA_W-1:0] wk_value [NUM_WAKEUP];

  logic [4:0]        src_arch  [4];
  logic [TAG_W-1:0]  src_tag   [4];
  logic              src_ready [4];
  logic [DATA_W-1:0] src_value [4];

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = (32'(p) + n) % 32'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_WAKEUP; k++) begin
      wk_tag[k]   = wakeup_tag[k*TAG_W +: TAG_W];
      wk_value[k] = wakeup_value[k*DATA_W +: DATA_W];
    end
  end

  // Frees arriving this cycle are deliberately not counted towards in_ready.
  always_comb begin
    need     = {1'b0, ard0 != 5'd0} + {1'b0, ard1 != 5'd0};
    need_cnt = {{(TAG_W-1){1'b0}}, need};
    in_ready = free_count >= need_cnt;
    accept   = in_valid && in_ready;
    head_p1  = ptr_add(head, 32'd1);
    prd0     = (ard0 != 5'd0) ? fl[head] : '0;
    prd1     = (ard1 != 5'd0) ? fl[(ard0 != 5'd0) ? head_p1 : head] : '0;
    head_n   = accept ? ptr_add(head, 32'(need)) : head;
  end

  // Slots 0..1 are the older instruction's sources, 2..3 the younger's.
  always_comb begin
    src_arch[0] = ars1_0;
    src_arch[1] = ars2_0;
    src_arch[2] = ars1_1;
    src_arch[3] = ars2_1;
    for (int s = 0; s < 4; s++) begin
      src_tag[s]   = '0;
      src_ready[s] = 1'b1;
      src_value[s] = '0;
      if (src_arch[s] != 5'd0) begin
        if (s >= 2 && ard0 != 5'd0 && src_arch[s] == ard0) begin
          src_tag[s]   = prd0;
          src_ready[s] = 1'b0;
          src_value[s] = '1;
        end else begin
          src_tag[s]   = rat_tag[src_arch[s]];
          src_ready[s] = rat_ready[src_arch[s]];
          src_value[s] = rat_ready[src_arch[s]] ? rat_value[src_arch[s]] : '1;
          for (int k = NUM_WAKEUP - 1; k >= 0; k--) begin
            if (wakeup_active[k] && wk_tag[k] != '0 && wk_tag[k] == src_tag[s]) begin
              src_ready[s] = 1'b1;
              src_value[s] = wk_value[k];
            end
          end
        end
      end
    end
  end

  assign prs1_0      = src_tag[0];
  assign prs2_0      = src_tag[1];
  assign prs1_1      = src_tag[2];
  assign prs2_1      = src_tag[3];
  assign rs1_ready_0 = src_ready[0];
  assign rs2_ready_0 = src_ready[1];
  assign rs1_ready_1 = src_ready[2];
  assign rs2_ready_1 = src_ready[3];
  assign rs1_value_0 = src_value[0];
  assign rs2_value_0 = src_value[1];
  assign rs1_value_1 = src_value[2];
  assign rs2_value_1 = src_value[3];

  // Wakeups apply first (highest port first so port 0 wins), renames override them.
  always_comb begin
    rat_tag_n   = rat_tag;
    rat_value_n = rat_value;
    rat_ready_n = rat_ready;
    for (int k = NUM_WAKEUP - 1; k >= 0; k--) begin
      if (wakeup_active[k] && wk_tag[k] != '0) begin
        for (int r = 1; r < NUM_ARCH; r++) begin
          if (rat_tag[r] == wk_tag[k]) begin
            rat_ready_n[r] = 1'b1;
            rat_value_n[r] = wk_value[k];
          end
        end
      end
    end
    if (accept) begin
      if (ard0 != 5'd0) begin
        rat_tag_n[ard0]   = prd0;
        rat_ready_n[ard0] = 1'b0;
        rat_value_n[ard0] = '1;
      end
      if (ard1 != 5'd0) begin
        rat_tag_n[ard1]   = prd1;
        rat_ready_n[ard1] = 1'b0;
        rat_value_n[ard1] = '1;
      end
    end
  end

  // Pushes see the occupancy after this cycle's pop; overflowing pushes are dropped.
  always_comb begin
    fl_n    = fl;
    tail_n  = tail;
    error_n = error;
    count_n = free_count - (accept ? need_cnt : '0);
    for (int p = 0; p < NUM_FREE; p++) begin
      if (freed_tag[p*TAG_W +: TAG_W] != '0) begin
        if (count_n < DEPTH_CNT) begin
          fl_n[tail_n] = freed_tag[p*TAG_W +: TAG_W];
          tail_n       = ptr_add(tail_n, 32'd1);
          count_n      = count_n + (TAG_W+1)'(1);
        end else begin
          error_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        rat_tag[r]   <= TAG_W'(r);
        rat_value[r] <= '0;
        rat_ready[r] <= 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fl[i] <= TAG_W'(NUM_ARCH + i);
      end
      head       <= '0;
      tail       <= '0;
      free_count <= DEPTH_CNT;
      error      <= 1'b0;
    end else begin
      rat_tag    <= rat_tag_n;
      rat_value  <= rat_value_n;
      rat_ready  <= rat_ready_n;
      fl         <= fl_n;
      head       <= head_n;
      tail       <= tail_n;
      free_count <= count_n;
      error      <= error_n;
    end
  end

endmodule

// File: tb/tb_rename_dual.sv
// Directed testbench for rename_dual: one task per scenario, hand-computed expectations.
module tb_rename_dual;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        ard0, ars1_0, ars2_0, ard1, ars1_1, ars2_1;
  logic [TAG_W-1:0]  prd0, prd1, prs1_0, prs2_0, prs1_1, prs2_1;
  logic              rs1_ready_0, rs2_ready_0, rs1_ready_1, rs2_ready_1;
  logic [DATA_W-1:0] rs1_value_0, rs2_value_0, rs1_value_1, rs2_value_1;
  logic [1:0]        wakeup_active;
  logic [2*TAG_W-1:0]  wakeup_tag;
  logic [2*DATA_W-1:0] wakeup_value;
  logic [2*TAG_W-1:0]  freed_tag;
  logic [TAG_W:0]    free_count;
  logic              error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_dual #(.NUM_PHYS(64), .DATA_W(32), .NUM_WAKEUP(2), .NUM_FREE(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ard0(ard0), .ars1_0(ars1_0), .ars2_0(ars2_0),
    .ard1(ard1), .ars1_1(ars1_1), .ars2_1(ars2_1),
    .prd0(prd0), .prd1(prd1), .prs1_0(prs1_0), .prs2_0(prs2_0), .prs1_1(prs1_1), .prs2_1(prs2_1),
    .rs1_ready_0(rs1_ready_0), .rs2_ready_0(rs2_ready_0), .rs1_ready_1(rs1_ready_1), .rs2_ready_1(rs2_ready_1),
    .rs1_value_0(rs1_value_0), .rs2_value_0(rs2_value_0), .rs1_value_1(rs1_value_1), .rs2_value_1(rs2_value_1),
    .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
    .freed_tag(freed_tag), .free_count(free_count), .error(error)
  );

  task automatic idle();
    in_valid = 1'b0;
    ard0 = 5'd0; ars1_0 = 5'd0; ars2_0 = 5'd0;
    ard1 = 5'd0; ars1_1 = 5'd0; ars2_1 = 5'd0;
    wakeup_active = '0; wakeup_tag = '0; wakeup_value = '0;
    freed_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    ars1_0 = 5'd5; ard0 = 5'd3;
    #1;
    checks++; if (free_count !== 7'd32) begin errors++; $display("[TB] FAIL reset_count got %0d exp 32", free_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b exp 0", error); end
    checks++; if (prs1_0 !== 6'd5) begin errors++; $display("[TB] FAIL reset_prs1_0 got %0d exp 5", prs1_0); end
    checks++; if (rs1_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", rs1_ready_0); end
    checks++; if (rs1_value_0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_value got %h exp 0", rs1_value_0); end
    checks++; if (prd0 !== 6'd32) begin errors++; $display("[TB] FAIL reset_prd0 got %0d exp 32", prd0); end
    checks++; if (prs2_0 !== 6'd0 || rs2_value_0 !== 32'h0 || rs2_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_x0 got tag %0d val %h rdy %b exp 0/0/1", prs2_0, rs2_value_0, rs2_ready_0); end
    idle();
  endtask

  task automatic test_basic_group();
    idle();
    ard0 = 5'd5; ard1 = 5'd6; in_valid = 1'b1;
    #1;
    checks++; if (prd0 !== 6'd32) begin errors++; $display("[TB] FAIL t1_prd0 got %0d exp 32", prd0); end
    checks++; if (prd1 !== 6'd33) begin errors++; $display("[TB] FAIL t1_prd1 got %0d exp 33", prd1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_in_ready got %b exp 1", in_ready); end
    step();
    idle();
    ars1_0 = 5'd5; ars2_0 = 5'd6;
    #1;
    checks++; if (free_count !== 7'd30) begin errors++; $display("[TB] FAIL t1_count got %0d exp 30", free_count); end
    checks++; if (prs1_0 !== 6'd32) begin errors++; $display("[TB] FAIL t1_rat_x5 got %0d exp 32", prs1_0); end
    checks++; if (rs1_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL t1_x5_ready got %b exp 0", rs1_ready_0); end
    checks++; if (rs1_value_0 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL t1_x5_value got %h exp ffffffff", rs1_value_0); end
    checks++; if (prs2_0 !== 6'd33) begin errors++; $display("[TB] FAIL t1_rat_x6 got %0d exp 33", prs2_0); end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    ard0 = 5'd7; ard1 = 5'd8; ars1_1 = 5'd7; ars2_1 = 5'd5; ars1_0 = 5'd7; in_valid = 1'b1;
    #1;
    checks++; if (prd0 !== 6'd34) begin errors++; $display("[TB] FAIL t2_prd0 got %0d exp 34", prd0); end
    checks++; if (prd1 !== 6'd35) begin errors++; $display("[TB] FAIL t2_prd1 got %0d exp 35", prd1); end
    checks++; if (prs1_1 !== 6'd34) begin errors++; $display("[TB] FAIL t2_bypass_tag got %0d exp 34", prs1_1); end
    checks++; if (rs1_ready_1 !== 1'b0) begin errors++; $display("[TB] FAIL t2_bypass_ready got %b exp 0", rs1_ready_1); end
    checks++; if (rs1_value_1 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL t2_bypass_value got %h exp ffffffff", rs1_value_1); end
    checks++; if (prs2_1 !== 6'd32 || rs2_ready_1 !== 1'b0) begin
      errors++; $display("[TB] FAIL t2_slot1_rat got %0d/%b exp 32/0", prs2_1, rs2_ready_1); end
    checks++; if (prs1_0 !== 6'd7 || rs1_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL t2_slot0_no_bypass got %0d/%b exp 7/1", prs1_0, rs1_ready_0); end
    step();
    idle();
    #1;
    checks++; if (free_count !== 7'd28) begin errors++; $display("[TB] FAIL t2_count got %0d exp 28", free_count); end
  endtask

  task automatic test_wakeup();
    idle();
    ars1_0 = 5'd5;
    wakeup_active = 2'b10; wakeup_tag = {6'd32, 6'd0}; wakeup_value = {32'h0000ABCD, 32'h0};
    #1;
    checks++; if (rs1_ready_0 !== 1'b1 || rs1_value_0 !== 32'h0000ABCD) begin
      errors++; $display("[TB] FAIL t3_forward got %b/%h exp 1/0000abcd", rs1_ready_0, rs1_value_0); end
    checks++; if (prs1_0 !== 6'd32) begin errors++; $display("[TB] FAIL t3_tag got %0d exp 32", prs1_0); end
    step();
    idle();
    ars1_0 = 5'd5;
    #1;
    checks++; if (rs1_ready_0 !== 1'b1 || rs1_value_0 !== 32'h0000ABCD) begin
      errors++; $display("[TB] FAIL t3_rat_written got %b/%h exp 1/0000abcd", rs1_ready_0, rs1_value_0); end
    ars2_0 = 5'd6;
    wakeup_active = 2'b11; wakeup_tag = {6'd33, 6'd33}; wakeup_value = {32'h2222, 32'h1111};
    #1;
    checks++; if (rs2_ready_0 !== 1'b1 || rs2_value_0 !== 32'h1111) begin
      errors++; $display("[TB] FAIL t3_port_prio got %b/%h exp 1/00001111", rs2_ready_0, rs2_value_0); end
    step();
    idle();
    ars2_0 = 5'd6;
    #1;
    checks++; if (rs2_ready_0 !== 1'b1 || rs2_value_0 !== 32'h1111) begin
      errors++; $display("[TB] FAIL t3_prio_rat got %b/%h exp 1/00001111", rs2_ready_0, rs2_value_0); end
    ard0 = 5'd7; in_valid = 1'b1;
    wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd34}; wakeup_value = {32'h0, 32'h5555};
    #1;
    checks++; if (prd0 !== 6'd36) begin errors++; $display("[TB] FAIL t3_prd0 got %0d exp 36", prd0); end
    step();
    idle();
    ars1_0 = 5'd7;
    #1;
    checks++; if (prs1_0 !== 6'd36 || rs1_ready_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL t3_rename_wins got %0d/%b exp 36/0", prs1_0, rs1_ready_0); end
    checks++; if (free_count !== 7'd27) begin errors++; $display("[TB] FAIL t3_count got %0d exp 27", free_count); end
    idle();
  endtask

  task automatic test_same_dest();
    idle();
    ard0 = 5'd9; ard1 = 5'd9; in_valid = 1'b1;
    #1;
    checks++; if (prd0 !== 6'd37 || prd1 !== 6'd38) begin
      errors++; $display("[TB] FAIL t5_prd got %0d/%0d exp 37/38", prd0, prd1); end
    step();
    idle();
    ars1_0 = 5'd9;
    wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd37}; wakeup_value = {32'h0, 32'h77};
    #1;
    checks++; if (prs1_0 !== 6'd38 || rs1_ready_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_final_map got %0d/%b exp 38/0", prs1_0, rs1_ready_0); end
    step();
    idle();
    ars1_0 = 5'd9; ars2_0 = 5'd6;
    wakeup_active = 2'b01; wakeup_tag = '0; wakeup_value = {32'h0, 32'h99};
    #1;
    checks++; if (rs1_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL t5_stale_wakeup got %b exp 0", rs1_ready_0); end
    checks++; if (rs2_value_0 !== 32'h1111) begin errors++; $display("[TB] FAIL t5_tag0_wakeup got %h exp 00001111", rs2_value_0); end
    step();
    idle();
    ars1_0 = 5'd9; ars2_0 = 5'd6;
    #1;
    checks++; if (rs1_ready_0 !== 1'b0 || rs2_value_0 !== 32'h1111) begin
      errors++; $display("[TB] FAIL t5_after got %b/%h exp 0/00001111", rs1_ready_0, rs2_value_0); end
    checks++; if (free_count !== 7'd25) begin errors++; $display("[TB] FAIL t5_count got %0d exp 25", free_count); end
    idle();
  endtask

  task automatic test_stall();
    idle();
    for (int i = 0; i < 12; i++) begin
      ard0 = 5'd10; ard1 = 5'd11; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_drain_ready iter %0d got %b exp 1", i, in_ready); end
      step();
      idle();
    end
    #1;
    checks++; if (free_count !== 7'd1) begin errors++; $display("[TB] FAIL t4_drained got %0d exp 1", free_count); end
    ard0 = 5'd12; ard1 = 5'd13; in_valid = 1'b1; ars1_0 = 5'd12;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_stall got %b exp 0", in_ready); end
    checks++; if (prd0 !== 6'd63) begin errors++; $display("[TB] FAIL t4_prd0 got %0d exp 63", prd0); end
    step();
    freed_tag = {6'd0, 6'd40};
    #1;
    checks++; if (free_count !== 7'd1) begin errors++; $display("[TB] FAIL t4_stall_count got %0d exp 1", free_count); end
    checks++; if (prs1_0 !== 6'd12 || rs1_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL t4_stall_rat got %0d/%b exp 12/1", prs1_0, rs1_ready_0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_same_cycle_free got %b exp 0", in_ready); end
    step();
    freed_tag = '0;
    #1;
    checks++; if (free_count !== 7'd2 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL t4_refilled got %0d/%b exp 2/1", free_count, in_ready); end
    checks++; if (prd0 !== 6'd63 || prd1 !== 6'd40) begin
      errors++; $display("[TB] FAIL t4_prd_wrap got %0d/%0d exp 63/40", prd0, prd1); end
    step();
    idle();
    ars1_0 = 5'd12; ars2_0 = 5'd13;
    #1;
    checks++; if (prs1_0 !== 6'd63 || prs2_0 !== 6'd40) begin
      errors++; $display("[TB] FAIL t4_accepted got %0d/%0d exp 63/40", prs1_0, prs2_0); end
    checks++; if (free_count !== 7'd0) begin errors++; $display("[TB] FAIL t4_empty got %0d exp 0", free_count); end
    ard0 = 5'd1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_empty_need1 got %b exp 0", in_ready); end
    ard0 = 5'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_empty_need0 got %b exp 1", in_ready); end
    idle();
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < 16; i++) begin
      freed_tag = {6'(2*i + 2), 6'(2*i + 1)};
      step();
    end
    idle();
    #1;
    checks++; if (free_count !== 7'd32 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL t6_refill got %0d/%b exp 32/0", free_count, error); end
    ard0 = 5'd3; in_valid = 1'b1; freed_tag = {6'd0, 6'd51};
    #1;
    checks++; if (prd0 !== 6'd1 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL t6_pop_push got %0d/%b exp 1/1", prd0, in_ready); end
    step();
    idle();
    #1;
    checks++; if (free_count !== 7'd32 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL t6_full_swap got %0d/%b exp 32/0", free_count, error); end
    freed_tag = {6'd0, 6'd50};
    step();
    idle();
    #1;
    checks++; if (error !== 1'b1 || free_count !== 7'd32) begin
      errors++; $display("[TB] FAIL t6_overflow got %b/%0d exp 1/32", error, free_count); end
    step();
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL t6_sticky got %b exp 1", error); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    ars1_0 = 5'd12;
    #1;
    checks++; if (error !== 1'b0 || free_count !== 7'd32 || prs1_0 !== 6'd12) begin
      errors++; $display("[TB] FAIL t6_reset got %b/%0d/%0d exp 0/32/12", error, free_count, prs1_0); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_bypass();
    test_wakeup();
    test_same_dest();
    test_stall();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached without finishing");
    $fatal(1, "[TB] timeout");
  end

endmodule
